// File: rtl/bp_cfg_responder_if.sv
// Config link bundle between the host-side initiator and a tile responder.
// Request channel is valid/ready; response channel is valid/yumi.
interface bp_cfg_responder_if #(
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64
);
  logic                        cfg_v_i;
  logic                        cfg_ready_o;
  logic                        cfg_w_v_i;
  logic [cfg_core_width_p-1:0] cfg_core_i;
  logic [cfg_addr_width_p-1:0] cfg_addr_i;
  logic [cfg_data_width_p-1:0] cfg_data_i;
  logic                        resp_v_o;
  logic                        resp_yumi_i;
  logic [cfg_data_width_p-1:0] resp_data_o;
  logic                        resp_err_o;

  modport master (
    output cfg_v_i, cfg_w_v_i, cfg_core_i,
    output cfg_addr_i, cfg_data_i, resp_yumi_i,
    input  cfg_ready_o, resp_v_o,
    input  resp_data_o, resp_err_o
  );

  modport slave (
    input  cfg_v_i, cfg_w_v_i, cfg_core_i,
    input  cfg_addr_i, cfg_data_i, resp_yumi_i,
    output cfg_ready_o, resp_v_o,
    output resp_data_o, resp_err_o
  );
endinterface

// File: rtl/bp_cfg_responder.sv
// Per-tile config target: decodes requests, holds arch config registers,
// and returns one response per addressed request.
module bp_cfg_responder #(
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int vaddr_width_p    = 39,
  parameter logic [vaddr_width_p-1:0] npc_reset_p = 39'h00_8000_0000
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [cfg_core_width_p-1:0] my_core_id_i,
  bp_cfg_responder_if.slave           cfg,
  output logic                        freeze_o,
  output logic [vaddr_width_p-1:0]    npc_o,
  output logic [1:0]                  icache_mode_o,
  output logic [1:0]                  dcache_mode_o,
  output logic                        cce_mode_o
);

  localparam int DW = cfg_data_width_p;
  localparam int AW = cfg_addr_width_p;

  localparam logic [AW-1:0] A_FREEZE  = AW'(1);
  localparam logic [AW-1:0] A_NPC     = AW'(2);
  localparam logic [AW-1:0] A_ICACHE  = AW'(3);
  localparam logic [AW-1:0] A_DCACHE  = AW'(4);
  localparam logic [AW-1:0] A_CCE     = AW'(5);
  localparam logic [AW-1:0] A_SCRATCH = AW'(6);

  typedef enum logic {
    e_ready,
    e_resp
  } state_e;

  state_e                   state_q;
  logic                     resp_v_q;
  logic [DW-1:0]            resp_data_q;
  logic                     resp_err_q;
  logic                     freeze_q;
  logic [vaddr_width_p-1:0] npc_q;
  logic [1:0]               icache_q;
  logic [1:0]               dcache_q;
  logic                     cce_q;
  logic [DW-1:0]            scratch_q;

  logic          sel_freeze;
  logic          sel_npc;
  logic          sel_icache;
  logic          sel_dcache;
  logic          sel_cce;
  logic          sel_scratch;
  logic          mapped;
  logic          hit_addr;
  logic          hit_bcast;
  logic          accept;
  logic          wr_en;
  logic [DW-1:0] rdata;
  logic [DW-1:0] resp_data_d;
  logic          resp_err_d;

  assign sel_freeze  = cfg.cfg_addr_i == A_FREEZE;
  assign sel_npc     = cfg.cfg_addr_i == A_NPC;
  assign sel_icache  = cfg.cfg_addr_i == A_ICACHE;
  assign sel_dcache  = cfg.cfg_addr_i == A_DCACHE;
  assign sel_cce     = cfg.cfg_addr_i == A_CCE;
  assign sel_scratch = cfg.cfg_addr_i == A_SCRATCH;

  assign mapped = sel_freeze | sel_npc | sel_icache
                | sel_dcache | sel_cce | sel_scratch;

  // An exact id match wins over broadcast, even for an all-ones tile id.
  assign hit_addr  = cfg.cfg_core_i == my_core_id_i;
  assign hit_bcast = (&cfg.cfg_core_i) & ~hit_addr;

  assign cfg.cfg_ready_o = (state_q == e_ready) & ~reset_i;
  assign accept          = cfg.cfg_v_i & cfg.cfg_ready_o;
  assign wr_en           = accept & cfg.cfg_w_v_i
                         & (hit_addr | hit_bcast);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_freeze:  rdata = DW'(freeze_q);
      sel_npc:     rdata = DW'(npc_q);
      sel_icache:  rdata = DW'(icache_q);
      sel_dcache:  rdata = DW'(dcache_q);
      sel_cce:     rdata = DW'(cce_q);
      sel_scratch: rdata = scratch_q;
      default:     rdata = '0;
    endcase
  end

  assign resp_data_d = cfg.cfg_w_v_i ? '0 : rdata;
  assign resp_err_d  = ~mapped;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_ready;
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      freeze_q    <= 1'b1;
      npc_q       <= npc_reset_p;
      icache_q    <= 2'b0;
      dcache_q    <= 2'b0;
      cce_q       <= 1'b0;
      scratch_q   <= '0;
    end else begin
      if (wr_en) begin
        if (sel_freeze)  freeze_q  <= cfg.cfg_data_i[0];
        if (sel_npc)     npc_q     <= cfg.cfg_data_i[vaddr_width_p-1:0];
        if (sel_icache)  icache_q  <= cfg.cfg_data_i[1:0];
        if (sel_dcache)  dcache_q  <= cfg.cfg_data_i[1:0];
        if (sel_cce)     cce_q     <= cfg.cfg_data_i[0];
        if (sel_scratch) scratch_q <= cfg.cfg_data_i;
      end
      unique case (state_q)
        e_ready: begin
          if (accept && hit_addr) begin
            state_q     <= e_resp;
            resp_v_q    <= 1'b1;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
          end
        end
        e_resp: begin
          if (cfg.resp_yumi_i) begin
            state_q  <= e_ready;
            resp_v_q <= 1'b0;
          end
        end
        default: state_q <= e_ready;
      endcase
    end
  end

  assign cfg.resp_v_o    = resp_v_q;
  assign cfg.resp_data_o = resp_data_q;
  assign cfg.resp_err_o  = resp_err_q;

  assign freeze_o      = freeze_q;
  assign npc_o         = npc_q;
  assign icache_mode_o = icache_q;
  assign dcache_mode_o = dcache_q;
  assign cce_mode_o    = cce_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(cfg.resp_yumi_i && !resp_v_q))
        else $error("resp_yumi_i without resp_v_o");
    end
  end
`endif

endmodule

// File: tb/tb_bp_cfg_responder.sv
// Directed and randomized checks of bp_cfg_responder against a
// register-map model kept as a plain array.
module tb_bp_cfg_responder;

  logic        clk;
  logic        reset;
  logic [7:0]  my_id;
  logic        freeze;
  logic [38:0] npc;
  logic [1:0]  imode;
  logic [1:0]  dmode;
  logic        cce;

  int total = 0;
  int bad   = 0;

  logic [63:0] mreg [0:7];

  bp_cfg_responder_if bus ();

  bp_cfg_responder dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .my_core_id_i  (my_id),
    .cfg           (bus.slave),
    .freeze_o      (freeze),
    .npc_o         (npc),
    .icache_mode_o (imode),
    .dcache_mode_o (dmode),
    .cce_mode_o    (cce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mapped(input logic [15:0] a);
    return (a >= 16'd1) && (a <= 16'd6);
  endfunction

  function automatic logic [63:0] mask_of(input logic [15:0] a);
    case (a)
      16'd1:   return 64'h1;
      16'd2:   return (64'h1 << 39) - 64'h1;
      16'd3:   return 64'h3;
      16'd4:   return 64'h3;
      16'd5:   return 64'h1;
      16'd6:   return '1;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] mread(input logic [15:0] a);
    return is_mapped(a) ? mreg[a[2:0]] : 64'h0;
  endfunction

  task automatic model_reset();
    foreach (mreg[i]) mreg[i] = 64'h0;
    mreg[1] = 64'h1;
    mreg[2] = 64'h80000000;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".freeze"}, 64'(freeze), mreg[1]);
    chk({tag, ".npc"},    64'(npc),    mreg[2]);
    chk({tag, ".imode"},  64'(imode),  mreg[3]);
    chk({tag, ".dmode"},  64'(dmode),  mreg[4]);
    chk({tag, ".cce"},    64'(cce),    mreg[5]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.ready_low", 64'(bus.cfg_ready_o), 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  // One request; yumi is held off for `hold` cycles after the response.
  task automatic send(input string tag,
                      input logic [7:0]  core,
                      input logic        w,
                      input logic [15:0] addr,
                      input logic [63:0] data,
                      input int          hold);
    logic        addressed;
    logic        match;
    logic [63:0] exp_d;
    logic        exp_e;
    addressed = (core == my_id);
    match     = addressed || (core == 8'hFF);
    exp_d     = w ? 64'h0 : mread(addr);
    exp_e     = !is_mapped(addr);
    @(negedge clk);
    chk({tag, ".ready"}, 64'(bus.cfg_ready_o), 64'h1);
    bus.cfg_v_i    = 1'b1;
    bus.cfg_w_v_i  = w;
    bus.cfg_core_i = core;
    bus.cfg_addr_i = addr;
    bus.cfg_data_i = data;
    @(posedge clk);
    #1;
    bus.cfg_v_i = 1'b0;
    if (match && w && is_mapped(addr))
      mreg[addr[2:0]] = data & mask_of(addr);
    chk_outs(tag);
    if (!addressed) begin
      chk({tag, ".no_resp"}, 64'(bus.resp_v_o), 64'h0);
      chk({tag, ".ready_again"}, 64'(bus.cfg_ready_o), 64'h1);
    end else begin
      chk({tag, ".resp_v"},   64'(bus.resp_v_o),   64'h1);
      chk({tag, ".resp_d"},   bus.resp_data_o,     exp_d);
      chk({tag, ".resp_err"}, 64'(bus.resp_err_o), 64'(exp_e));
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        chk({tag, ".hold_v"},     64'(bus.resp_v_o),    64'h1);
        chk({tag, ".hold_d"},     bus.resp_data_o,      exp_d);
        chk({tag, ".hold_e"},     64'(bus.resp_err_o),  64'(exp_e));
        chk({tag, ".hold_ready"}, 64'(bus.cfg_ready_o), 64'h0);
      end
      @(negedge clk);
      bus.resp_yumi_i = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_yumi_i = 1'b0;
      chk({tag, ".post_v"},     64'(bus.resp_v_o),    64'h0);
      chk({tag, ".post_ready"}, 64'(bus.cfg_ready_o), 64'h1);
    end
  endtask

  initial begin
    logic [7:0]  cores [3];
    logic [15:0] ra;
    logic [63:0] rd;
    cores[0] = 8'd3;
    cores[1] = 8'd5;
    cores[2] = 8'hFF;
    reset           = 1'b1;
    my_id           = 8'd3;
    bus.cfg_v_i     = 1'b0;
    bus.cfg_w_v_i   = 1'b0;
    bus.cfg_core_i  = '0;
    bus.cfg_addr_i  = '0;
    bus.cfg_data_i  = '0;
    bus.resp_yumi_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle.npc", 64'(npc), 64'h80000000);
    chk("idle.freeze", 64'(freeze), 64'h1);
    chk("idle.ready", 64'(bus.cfg_ready_o), 64'h1);
    chk("idle.resp_v", 64'(bus.resp_v_o), 64'h0);
    chk("idle.resp_d", bus.resp_data_o, 64'h0);
    chk("idle.resp_e", 64'(bus.resp_err_o), 64'h0);
    chk_outs("idle");

    send("unfreeze", 8'd3, 1'b1, 16'h0001, 64'h0, 0);
    send("scr_wr", 8'd3, 1'b1, 16'h0006, 64'hDEAD_BEEF_0123_4567, 0);
    send("scr_rd", 8'd3, 1'b0, 16'h0006, 64'h0, 0);
    send("ic_wr", 8'd3, 1'b1, 16'h0003, 64'hFF, 1);
    send("ic_rd", 8'd3, 1'b0, 16'h0003, 64'h0, 0);
    send("npc_wr", 8'd3, 1'b1, 16'h0002, '1, 0);
    send("npc_rd", 8'd3, 1'b0, 16'h0002, 64'h0, 0);
    send("unmap_rd", 8'd3, 1'b0, 16'h0100, 64'h0, 0);
    send("unmap_wr", 8'd3, 1'b1, 16'h0000, 64'h1234, 0);
    send("other_core", 8'd5, 1'b1, 16'h0001, 64'h1, 0);
    send("bcast_cce", 8'hFF, 1'b1, 16'h0005, 64'h1, 0);
    send("bcast_rd", 8'hFF, 1'b0, 16'h0006, 64'h0, 0);
    send("long_hold", 8'd3, 1'b0, 16'h0006, 64'h0, 10);

    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 16'h0100
         : 16'($urandom_range(0, 7));
      rd = {$urandom, $urandom};
      send($sformatf("rnd%0d", i), cores[$urandom_range(0, 2)],
           1'($urandom_range(0, 1)), ra, rd, $urandom_range(0, 3));
    end

    send("pre_rst_wr", 8'd3, 1'b1, 16'h0006, 64'hCAFE_F00D, 0);
    @(negedge clk);
    bus.cfg_v_i    = 1'b1;
    bus.cfg_w_v_i  = 1'b0;
    bus.cfg_core_i = 8'd3;
    bus.cfg_addr_i = 16'h0006;
    @(posedge clk);
    #1;
    bus.cfg_v_i = 1'b0;
    chk("mid.resp_v", 64'(bus.resp_v_o), 64'h1);
    do_reset();
    chk("mid.after_v", 64'(bus.resp_v_o), 64'h0);
    chk("mid.after_ready", 64'(bus.cfg_ready_o), 64'h1);
    chk_outs("mid.after");
    send("mid.scr_rd", 8'd3, 1'b0, 16'h0006, 64'h0, 0);

    my_id = 8'hFF;
    do_reset();
    send("allones_rd", 8'hFF, 1'b0, 16'h0001, 64'h0, 0);
    send("allones_wr", 8'hFF, 1'b1, 16'h0004, 64'h2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
